cordic_iter: RTL and testbench
==============================

# cordic_iter

Iterative CORDIC engine directly downstream of the CORDIC init stage. It accepts the Q16.16 x/y/angle triple and the 4-bit select word from init. It runs ITER micro-rotations in rotation mode (sin/cos) or vectoring mode (arctan/magnitude), then applies gain compensation. The result is presented to the output formatting stage with a one-cycle valid pulse.

## Interface
- ITER, 16, number of CORDIC iterations (legal 8..24).
- KINV, 32'h00009B75, Q16.16 reciprocal CORDIC gain (0.607253).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- x_in  in  32  signed Q16.16 start x from init.
- y_in  in  32  signed Q16.16 start y from init.
- z_in  in  32  signed Q16.16 start angle in degrees from init.
- select_in  in  4  op select from init; bit 3 = 1 selects vectoring, 0 selects rotation.
- valid_in  in  1  one-cycle strobe, qualifies all *_in signals.
- ready  out  1  high when idle and able to accept.
- x_out  out  32  signed Q16.16 compensated x (cos, or magnitude).
- y_out  out  32  signed Q16.16 compensated y (sin, or residual).
- z_out  out  32  signed Q16.16 degrees (residual angle, or atan(y/x)).
- select_out  out  4  select word captured at accept.
- valid_out  out  1  one-cycle result strobe.
- drop  out  1  sticky: a valid_in arrived while busy.

## Operation
- FSM states: IDLE, RUN, COMP.
- **IDLE**
  - ready=1.
  - On valid_in: load x/y/z working registers, capture select_in, clear iteration counter i, go to RUN.
- **RUN**, one iteration per cycle, i = 0..ITER-1:
  - Rotation mode: d=+1 if z≥0, else −1.
  - Vectoring mode: d=+1 if y<0, else −1.
  - x' = x − d·(y>>>i); y' = y + d·(x>>>i); z' = z − d·atan_i.
  - Shifts are arithmetic; add/sub are 32-bit two's complement and wrap silently.
  - atan_i is a constant table: round(atan(2^-i)·180/π·65536), e.g. i0=32'h002D0000, i1=32'h001A90A7.
  - After iteration ITER-1, go to COMP.
- **COMP**
  - x_out = (x·KINV)>>>16 and y_out = (y·KINV)>>>16, using a signed 64-bit product truncated to 32 bits.
  - z_out = z (not compensated).
  - select_out = captured select.
  - Pulse valid_out and return to IDLE.
- Outputs hold their last result until the next COMP.
- Busy input: valid_in while ready=0 is ignored; working state is unaffected and drop is set. Only rst clears drop.
- Input ranges are the caller's responsibility:
  - Rotation converges for |z| ≤ 99.88°.
  - Vectoring requires x_in ≥ 0.

## Timing
- Accept edge E0 is a rising edge with valid_in=1 and ready=1.
- Iterations occur at E1..E_ITER. Compensation occurs at E_ITER+1.
- valid_out is high for the single cycle following E_ITER+1. Latency is ITER+1 edges (17 for the default).
- ready drops the cycle after E0 and returns high in the same cycle valid_out is high. A valid_in in that cycle is accepted, giving back-to-back issue every ITER+2 cycles.
- Because upstream has no backpressure, it must space its valid pulses by at least ITER+2 cycles.
- Reset values:
  - state = IDLE, ready = 1.
  - valid_out = 0, drop = 0.
  - x_out, y_out, z_out = 0; select_out = 0.
  - Working registers and counter = 0.
- Reset asserted mid-RUN aborts the operation immediately. No valid_out is produced for the aborted operation.

## Test plan
- **Rotation 30°:** x_in=32'h00010000, y_in=0, z_in=32'h001E0000, select_in=0 -> valid_out exactly 17 edges after accept with x_out≈0xDDB4 (±16 LSB), y_out≈0x8000 (±16), |z_out|≤256 LSB, select_out=0.
- **Rotation 0° and 90°:** x_in=1.0, y_in=0, with z_in=0 and then z_in=32'h005A0000 -> (x_out, y_out) ≈ (0x10000, 0) and ≈ (0, 0x10000) respectively, ±16 LSB.
- **Vectoring:** x_in=y_in=32'h00010000, select_in=4'b1000 -> z_out≈32'h002D0000 (±256), x_out≈0x16A0A (±16), y_out≈0 (±16), select_out=4'b1000.
- **Busy drop:** second valid_in 5 cycles after accept, with different data -> drop=1, the first result is unchanged, and exactly one valid_out appears.
- **Back-to-back:** second valid_in in the cycle valid_out=1 -> accepted, drop stays 0, second valid_out arrives ITER+2 cycles after the first.
- **Reset mid-run:** rst pulsed at E8 -> all outputs read zero, ready=1, no valid_out. A new op issued afterwards completes normally.

Source files
------------

// File: rtl/cordic_iter.sv
// Iterative CORDIC engine: one micro-rotation per clock in rotation (sin/cos) or
// vectoring (atan/magnitude) mode, followed by a gain-compensation cycle.
module cordic_iter #(
  parameter int          ITER = 16,
  parameter logic [31:0] KINV = 32'h00009B75
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] x_in,
  input  logic [31:0] y_in,
  input  logic [31:0] z_in,
  input  logic [3:0]  select_in,
  input  logic        valid_in,
  output logic        ready,
  output logic [31:0] x_out,
  output logic [31:0] y_out,
  output logic [31:0] z_out,
  output logic [3:0]  select_out,
  output logic        valid_out,
  output logic        drop
);

  typedef enum logic [1:0] {IDLE, RUN, COMP} state_t;

  localparam logic signed [63:0] KINV_W = 64'($signed(KINV));

  state_t             state, state_next;
  logic signed [31:0] x_r, y_r, z_r;
  logic signed [31:0] x_sh, y_sh, atan_i;
  logic [3:0]         sel_r;
  logic [4:0]         iter_cnt;
  logic               d_pos;
  logic               last_iter;

  // round(atan(2^-i) * 180/pi * 65536); entries past 23 round to zero.
  function automatic logic [31:0] atan_lut(input logic [4:0] idx);
    case (idx)
      5'd0:    atan_lut = 32'h002D0000;
      5'd1:    atan_lut = 32'h001A90A7;
      5'd2:    atan_lut = 32'h000E0947;
      5'd3:    atan_lut = 32'h00072001;
      5'd4:    atan_lut = 32'h0003938B;
      5'd5:    atan_lut = 32'h0001CA38;
      5'd6:    atan_lut = 32'h0000E52A;
      5'd7:    atan_lut = 32'h00007297;
      5'd8:    atan_lut = 32'h0000394C;
      5'd9:    atan_lut = 32'h00001CA6;
      5'd10:   atan_lut = 32'h00000E53;
      5'd11:   atan_lut = 32'h00000729;
      5'd12:   atan_lut = 32'h00000395;
      5'd13:   atan_lut = 32'h000001CA;
      5'd14:   atan_lut = 32'h000000E5;
      5'd15:   atan_lut = 32'h00000073;
      5'd16:   atan_lut = 32'h00000039;
      5'd17:   atan_lut = 32'h0000001D;
      5'd18:   atan_lut = 32'h0000000E;
      5'd19:   atan_lut = 32'h00000007;
      5'd20:   atan_lut = 32'h00000004;
      5'd21:   atan_lut = 32'h00000002;
      5'd22:   atan_lut = 32'h00000001;
      default: atan_lut = 32'h00000000;
    endcase
  endfunction

  assign ready     = (state == IDLE);
  assign last_iter = (iter_cnt == 5'(ITER - 1));

  // Vectoring drives y toward zero, rotation drives z toward zero.
  always_comb begin
    x_sh   = x_r >>> iter_cnt;
    y_sh   = y_r >>> iter_cnt;
    atan_i = atan_lut(iter_cnt);
    d_pos  = sel_r[3] ? y_r[31] : ~z_r[31];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: every variable assigned here gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (valid_in)  state_next = RUN;
      RUN:     if (last_iter) state_next = COMP;
      COMP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // NOTE: registered state uses non-blocking assignments so all updates see pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_r        <= '0;
      y_r        <= '0;
      z_r        <= '0;
      sel_r      <= '0;
      iter_cnt   <= '0;
      x_out      <= '0;
      y_out      <= '0;
      z_out      <= '0;
      select_out <= '0;
      valid_out  <= 1'b0;
      drop       <= 1'b0;
    end else begin
      valid_out <= 1'b0;
      if (valid_in && (state != IDLE)) drop <= 1'b1;
      case (state)
        IDLE: if (valid_in) begin
          x_r      <= x_in;
          y_r      <= y_in;
          z_r      <= z_in;
          sel_r    <= select_in;
          iter_cnt <= '0;
        end
        RUN: begin
          if (d_pos) begin
            x_r <= x_r - y_sh;
            y_r <= y_r + x_sh;
            z_r <= z_r - atan_i;
          end else begin
            x_r <= x_r + y_sh;
            y_r <= y_r - x_sh;
            z_r <= z_r + atan_i;
          end
          iter_cnt <= iter_cnt + 5'd1;
        end
        COMP: begin
          x_out      <= 32'((64'(x_r) * KINV_W) >>> 16);
          y_out      <= 32'((64'(y_r) * KINV_W) >>> 16);
          z_out      <= z_r;
          select_out <= sel_r;
          valid_out  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: known angles and vectors with hand-computed
// results, latency, busy-drop, back-to-back issue and reset abort.
module tb_cordic_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] x_in, y_in, z_in;
  logic [3:0]  select_in;
  logic        valid_in;
  logic        ready;
  logic [31:0] x_out, y_out, z_out;
  logic [3:0]  select_out;
  logic        valid_out;
  logic        drop;

  int checks = 0;
  int errors = 0;

  localparam logic [31:0] ONE = 32'h00010000;

  cordic_iter dut (
    .clk(clk), .rst(rst),
    .x_in(x_in), .y_in(y_in), .z_in(z_in), .select_in(select_in), .valid_in(valid_in),
    .ready(ready),
    .x_out(x_out), .y_out(y_out), .z_out(z_out), .select_out(select_out),
    .valid_out(valid_out), .drop(drop)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp,
                       input int tol = 0);
    longint diff;
    checks++;
    diff = longint'($signed(obs)) - longint'($signed(exp));
    if (diff < 0) diff = -diff;
    if (diff > longint'(tol)) begin
      errors++;
      $display("FAIL %s: got 0x%08h want 0x%08h (tol %0d)", tag, obs, exp, tol);
    end
  endtask

  task automatic drive(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                       input logic [3:0] sel);
    x_in = x; y_in = y; z_in = z; select_in = sel; valid_in = 1'b1;
  endtask

  // Issues one op from an idle point (#1 after an edge); returns edges from accept to
  // the first cycle valid_out is seen, or -1 if none appears within the budget.
  task automatic run_op(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z,
                        input logic [3:0] sel, output int lat);
    drive(x, y, z, sel);
    @(posedge clk); #1;
    valid_in = 1'b0;
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (valid_out) begin
        lat = c;
        break;
      end
    end
  endtask

  initial begin
    int lat, pulses, first;
    rst = 1'b1; valid_in = 1'b0;
    x_in = '0; y_in = '0; z_in = '0; select_in = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    check("rst_ready", 32'(ready), 32'd1);
    check("rst_valid", 32'(valid_out), 32'd0);
    check("rst_drop", 32'(drop), 32'd0);
    check("rst_x", x_out, 32'd0);
    check("rst_sel", 32'(select_out), 32'd0);
    @(posedge clk); #1;

    run_op(ONE, 32'd0, 32'h001E0000, 4'b0000, lat);
    check("rot30_lat", 32'(lat), 32'd17);
    check("rot30_x", x_out, 32'h0000DDB4, 16);
    check("rot30_y", y_out, 32'h00008000, 16);
    check("rot30_z", z_out, 32'd0, 256);
    check("rot30_sel", 32'(select_out), 32'd0);
    @(posedge clk); #1;
    check("pulse_one_cycle", 32'(valid_out), 32'd0);

    run_op(ONE, 32'd0, 32'd0, 4'b0010, lat);
    check("rot0_lat", 32'(lat), 32'd17);
    check("rot0_x", x_out, ONE, 16);
    check("rot0_y", y_out, 32'd0, 16);
    check("rot0_sel", 32'(select_out), 32'd2);
    @(posedge clk); #1;

    run_op(ONE, 32'd0, 32'h005A0000, 4'b0001, lat);
    check("rot90_x", x_out, 32'd0, 16);
    check("rot90_y", y_out, ONE, 16);
    @(posedge clk); #1;

    run_op(ONE, ONE, 32'd0, 4'b1000, lat);
    check("vec_lat", 32'(lat), 32'd17);
    check("vec_z", z_out, 32'h002D0000, 256);
    check("vec_x", x_out, 32'h00016A0A, 16);
    check("vec_y", y_out, 32'd0, 16);
    check("vec_sel", 32'(select_out), 32'd8);
    @(posedge clk); #1;

    // Back-to-back: second op issued in the valid_out cycle.
    run_op(ONE, 32'd0, 32'h005A0000, 4'b0011, lat);
    check("b2b_ready", 32'(ready), 32'd1);
    drive(ONE, ONE, 32'd0, 4'b1001);
    lat = -1;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk); #1;
      if (c == 1) valid_in = 1'b0;
      if (valid_out) begin
        lat = c;
        break;
      end
    end
    check("b2b_gap", 32'(lat), 32'd18);
    check("b2b_drop", 32'(drop), 32'd0);
    check("b2b_z", z_out, 32'h002D0000, 256);
    check("b2b_sel", 32'(select_out), 32'd9);
    @(posedge clk); #1;

    // Busy drop: an intruding valid_in during RUN must be ignored.
    drive(ONE, 32'd0, 32'h001E0000, 4'b0100);
    @(posedge clk); #1;
    valid_in = 1'b0;
    pulses = 0; first = -1;
    for (int c = 1; c <= 45; c++) begin
      @(posedge clk); #1;
      if (c == 5) drive(32'h00020000, ONE, 32'h00100000, 4'b1111);
      if (c == 6) valid_in = 1'b0;
      if (valid_out) begin
        pulses++;
        if (first < 0) first = c;
      end
    end
    check("busy_drop", 32'(drop), 32'd1);
    check("busy_pulses", 32'(pulses), 32'd1);
    check("busy_lat", 32'(first), 32'd17);
    check("busy_x", x_out, 32'h0000DDB4, 16);
    check("busy_y", y_out, 32'h00008000, 16);
    check("busy_sel", 32'(select_out), 32'd4);

    // Reset mid-run aborts with no result.
    drive(ONE, 32'd0, 32'h001E0000, 4'b0110);
    @(posedge clk); #1;
    valid_in = 1'b0;
    repeat (7) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    check("abort_x", x_out, 32'd0);
    check("abort_y", y_out, 32'd0);
    check("abort_z", z_out, 32'd0);
    check("abort_sel", 32'(select_out), 32'd0);
    check("abort_ready", 32'(ready), 32'd1);
    check("abort_drop", 32'(drop), 32'd0);
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(posedge clk); #1;
      if (valid_out) pulses++;
    end
    check("abort_no_valid", 32'(pulses), 32'd0);

    run_op(ONE, 32'd0, 32'h001E0000, 4'b0101, lat);
    check("post_lat", 32'(lat), 32'd17);
    check("post_x", x_out, 32'h0000DDB4, 16);
    check("post_y", y_out, 32'h00008000, 16);
    check("post_sel", 32'(select_out), 32'd5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
